bp_lite_to_burst_buffered: RTL

BP_LITE_TO_BURST_BUFFERED -- requirements
Module: bp_lite_to_burst_buffered

---
 rtl/bp_me_pkg.sv | 21 ++
 rtl/bp_lite_to_burst_fifo.sv | 48 ++++
 rtl/bp_lite_to_burst_buffered.sv | 109 ++++++++++
 3 files changed

// File: rtl/bp_me_pkg.sv
// bp_me_pkg: shared types and helpers for the lite-to-burst converter.
// Lite header layout (LSB first): msg_type[3:0], size[2:0], paddr, payload.
package bp_me_pkg;
  typedef enum logic [1:0] {e_bp_default_cfg, e_bp_small_cfg} bp_params_e;
  typedef enum logic [1:0] {e_idle, e_send, e_done} bp_lite_to_burst_state_e;
  localparam int unsigned msg_type_width_gp = 4;
  localparam int unsigned msg_size_width_gp = 3;
  function automatic int unsigned bp_paddr_width(bp_params_e cfg);
    return (cfg == e_bp_small_cfg) ? 32'd32 : 32'd40;
  endfunction
  function automatic int unsigned bp_lite_hdr_width(bp_params_e cfg, int unsigned payload_w);
    return msg_type_width_gp + msg_size_width_gp + bp_paddr_width(cfg) + payload_w;
  endfunction
  // sizes larger than the lite data word are clamped to a full burst
  function automatic int unsigned bp_lite_num_beats(logic [2:0] size, int unsigned out_bytes,
                                                    int unsigned words);
    int unsigned b;
    b = (32'd1 << size) / out_bytes;
    return (b < 32'd1) ? 32'd1 : (b > words) ? words : b;
  endfunction
endpackage

// File: rtl/bp_lite_to_burst_fifo.sv
// bp_lite_to_burst_fifo: circular message buffer, ready-valid-and in, valid-yumi out.
module bp_lite_to_burst_fifo #(
  parameter int unsigned width_p = 1,
  parameter int unsigned els_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_and_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i,
  output logic               v_next_o
);
  localparam int unsigned ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned cnt_w_lp = $clog2(els_p + 1);
  logic [width_p-1:0] mem_q [els_p];
  logic [ptr_w_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic enq;
  function automatic logic [ptr_w_lp-1:0] inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction
  // yumi is registered upstream, so a full buffer can accept while it dequeues
  assign ready_and_o = (cnt_q != cnt_w_lp'(els_p)) | yumi_i;
  assign enq = v_i & ready_and_o;
  assign v_o = cnt_q != '0;
  assign data_o = mem_q[rptr_q];
  assign v_next_o = cnt_d != '0;
  always_comb begin
    wptr_d = enq ? inc(wptr_q) : wptr_q;
    rptr_d = yumi_i ? inc(rptr_q) : rptr_q;
    cnt_d = cnt_q + cnt_w_lp'(enq) - cnt_w_lp'(yumi_i);
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk_i)
    if (enq) mem_q[wptr_q] <= data_i;
endmodule

// File: rtl/bp_lite_to_burst_buffered.sv
// bp_lite_to_burst_buffered: buffers lite messages and replays each as header plus data burst.
// Defining BP_LITE_TO_BURST_STATS_EN adds dequeue and beat counters.
module bp_lite_to_burst_buffered
  import bp_me_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int unsigned in_data_width_p = 512,
  parameter int unsigned out_data_width_p = 64,
  parameter int unsigned payload_width_p = 0,
  parameter logic [15:0] payload_mask_p = '0,
  parameter int unsigned buffer_els_p = 2,
  localparam int unsigned hdr_width_lp = bp_lite_hdr_width(bp_params_p, payload_width_p),
  localparam int unsigned in_msg_width_lp = hdr_width_lp + in_data_width_p,
  localparam int unsigned burst_words_lp = in_data_width_p / out_data_width_p
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [in_msg_width_lp-1:0]  in_msg_i,
  input  logic                        in_msg_v_i,
  output logic                        in_msg_ready_and_o,
  output logic [hdr_width_lp-1:0]     out_msg_header_o,
  output logic                        out_msg_header_v_o,
  input  logic                        out_msg_header_ready_and_i,
  output logic                        out_msg_has_data_o,
  output logic [out_data_width_p-1:0] out_msg_data_o,
  output logic                        out_msg_data_v_o,
  input  logic                        out_msg_data_ready_and_i,
  output logic                        out_msg_last_o,
`ifdef BP_LITE_TO_BURST_STATS_EN
  output logic [31:0]                 msg_count_o,
  output logic [31:0]                 beat_count_o,
`endif
  output logic                        idle_o
);
  localparam int unsigned bw_lp = $clog2(burst_words_lp + 1);
  if (in_data_width_p % out_data_width_p != 0) begin : g_chk_ratio
    $error("in_data_width_p must be a multiple of out_data_width_p");
  end
  if (in_data_width_p < out_data_width_p) begin : g_chk_width
    $error("in_data_width_p must be >= out_data_width_p");
  end
  if (buffer_els_p < 1) begin : g_chk_els
    $error("buffer_els_p must be >= 1");
  end
  bp_lite_to_burst_state_e state_q, state_d;
  logic header_sent_q, header_sent_d;
  logic [bw_lp-1:0] beat_q, beat_d, num_beats;
  logic [in_msg_width_lp-1:0] head;
  logic [hdr_width_lp-1:0] hdr;
  logic [in_data_width_p-1:0] data_sh;
  logic head_v, v_next, yumi, fifo_ready, has_payload, hdr_done, burst_done, send;
  bp_lite_to_burst_fifo #(.width_p(in_msg_width_lp), .els_p(buffer_els_p)) fifo (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .data_i(in_msg_i),
    .v_i(in_msg_v_i),
    .ready_and_o(fifo_ready),
    .data_o(head),
    .v_o(head_v),
    .yumi_i(yumi),
    .v_next_o(v_next)
  );
  assign in_msg_ready_and_o = reset_n_i & fifo_ready;
  assign hdr = head[hdr_width_lp-1:0];
  assign has_payload = payload_mask_p[hdr[3:0]];
  assign num_beats = bw_lp'(bp_lite_num_beats(hdr[6:4], out_data_width_p / 8, burst_words_lp));
  assign data_sh = head[hdr_width_lp +: in_data_width_p] >> (32'(beat_q) * out_data_width_p);
  assign out_msg_header_o = hdr;
  assign out_msg_data_o = data_sh[out_data_width_p-1:0];
  assign idle_o = (state_q == e_idle) & !head_v;
  always_comb begin
    send = state_q == e_send;
    yumi = state_q == e_done;
    out_msg_header_v_o = send & !header_sent_q;
    out_msg_has_data_o = out_msg_header_v_o & has_payload;
    out_msg_data_v_o = send & has_payload & (beat_q != num_beats);
    out_msg_last_o = out_msg_data_v_o & (beat_q == num_beats - bw_lp'(1));
    hdr_done = header_sent_q | (out_msg_header_v_o & out_msg_header_ready_and_i);
    burst_done = !has_payload | (beat_q == num_beats) | (out_msg_last_o & out_msg_data_ready_and_i);
    header_sent_d = send & hdr_done;
    beat_d = yumi ? '0 : beat_q + bw_lp'(out_msg_data_v_o & out_msg_data_ready_and_i);
    state_d = (state_q == e_idle) ? (head_v ? e_send : e_idle)
            : send ? ((hdr_done & burst_done) ? e_done : e_send)
            : (v_next ? e_send : e_idle);
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_q <= e_idle;
      header_sent_q <= 1'b0;
      beat_q <= '0;
    end else begin
      state_q <= state_d;
      header_sent_q <= header_sent_d;
      beat_q <= beat_d;
    end
`ifdef BP_LITE_TO_BURST_STATS_EN
  logic [31:0] msg_count_q, beat_count_q;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      msg_count_q <= '0;
      beat_count_q <= '0;
    end else begin
      msg_count_q <= msg_count_q + 32'(yumi);
      beat_count_q <= beat_count_q + 32'(out_msg_data_v_o & out_msg_data_ready_and_i);
    end
  assign msg_count_o = msg_count_q;
  assign beat_count_o = beat_count_q;
`endif
endmodule
